// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset controller: Moore main FSM, ALU decoder, condition
// check and flag registers driving the shared-memory datapath.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [3:0] Flags,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  state_t     r_state, w_next;
  logic [3:0] r_flags;
  logic       r_condex;

  logic       w_nextpc, w_regw, w_memw, w_aluop, w_branch, w_irw, w_adr, w_asa;
  logic [1:0] w_asb, w_res, w_aluctl, w_flagw;
  logic       w_nowrite, w_condex, w_pcs;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_FETCH;
      r_flags  <= 4'b0000;
      r_condex <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_condex <= w_condex;
      if (w_flagw[1] & r_condex) r_flags[3:2] <= ALUFlags[3:2];
      if (w_flagw[0] & r_condex) r_flags[1:0] <= ALUFlags[1:0];
    end
  end

  always_comb begin
    w_next   = S_FETCH;
    w_nextpc = 1'b0;
    w_irw    = 1'b0;
    w_adr    = 1'b0;
    w_asa    = 1'b0;
    w_asb    = 2'b00;
    w_res    = 2'b00;
    w_regw   = 1'b0;
    w_memw   = 1'b0;
    w_aluop  = 1'b0;
    w_branch = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_next = S_DECODE; w_irw = 1'b1; w_nextpc = 1'b1;
        w_asa = 1'b1; w_asb = 2'b10; w_res = 2'b10;
      end
      S_DECODE: begin
        w_asa = 1'b1; w_asb = 2'b10; w_res = 2'b10;
        case (Op)
          2'b00:   w_next = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b01:   w_next = S_MEMADR;
          2'b10:   w_next = S_BRANCH;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        w_asb  = 2'b01;
        w_next = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD:  begin w_adr = 1'b1; w_next = S_MEMWB; end
      S_MEMWB:    begin w_res = 2'b01; w_regw = 1'b1; end
      S_MEMWRITE: begin w_adr = 1'b1; w_memw = 1'b1; end
      S_EXECUTER: begin w_aluop = 1'b1; w_next = S_ALUWB; end
      S_EXECUTEI: begin w_asb = 2'b01; w_aluop = 1'b1; w_next = S_ALUWB; end
      S_ALUWB:    w_regw = 1'b1;
      S_BRANCH:   begin w_asb = 2'b01; w_res = 2'b10; w_branch = 1'b1; end
      default:    ;
    endcase
  end

  always_comb begin
    w_aluctl = 2'b00;
    if (w_aluop) begin
      case (Funct[4:1])
        4'b0100: w_aluctl = 2'b00;
        4'b0010: w_aluctl = 2'b01;
        4'b0000: w_aluctl = 2'b10;
        4'b1100: w_aluctl = 2'b11;
        4'b1010: w_aluctl = 2'b01;
        default: w_aluctl = 2'b00;
      endcase
    end
    w_flagw[1] = w_aluop & Funct[0];
    w_flagw[0] = w_aluop & Funct[0] & ~w_aluctl[1];
  end

  // NoWrite must still be seen in ALUWB, where ALUOp is already 0, so it is
  // decoded straight from the (stable) instruction fields.
  assign w_nowrite = (Op == 2'b00) && (Funct[4:1] == 4'b1010);

  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = r_flags;
    case (Cond)
      4'b0000: w_condex = z;
      4'b0001: w_condex = ~z;
      4'b0010: w_condex = c;
      4'b0011: w_condex = ~c;
      4'b0100: w_condex = n;
      4'b0101: w_condex = ~n;
      4'b0110: w_condex = v;
      4'b0111: w_condex = ~v;
      4'b1000: w_condex = c & ~z;
      4'b1001: w_condex = ~(c & ~z);
      4'b1010: w_condex = (n == v);
      4'b1011: w_condex = (n != v);
      4'b1100: w_condex = ~z & (n == v);
      4'b1101: w_condex = ~(~z & (n == v));
      4'b1110: w_condex = 1'b1;
      default: w_condex = 1'b0;
    endcase
  end

  assign w_pcs      = w_branch | (w_regw & (Rd == 4'hF));
  assign PCWrite    = w_nextpc | (w_pcs & r_condex);
  assign RegWrite   = w_regw & r_condex & ~w_nowrite;
  assign MemWrite   = w_memw & r_condex;
  assign IRWrite    = w_irw;
  assign AdrSrc     = w_adr;
  assign ALUSrcA    = w_asa;
  assign ALUSrcB    = w_asb;
  assign ResultSrc  = w_res;
  assign ALUControl = w_aluctl;
  assign ImmSrc     = Op;
  assign RegSrc     = {Op == 2'b01, Op == 2'b10};
  assign Flags      = r_flags;
  assign State      = r_state;

endmodule
